// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator between the execute stage and a word-only data
//   memory (synchronous write, combinational read). Byte/half/word loads are
//   lane-extracted and sign/zero extended; sub-word stores are done as a
//   read-modify-write. Misaligned or reserved-size requests complete with err.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   req, we, size, sign_ext request strobe (sampled in IDLE) and attributes
//   addr, wdata             byte address, right-justified store data
//   busy, done, err         status: busy != IDLE, one-cycle done, error flag
//   rdata                   load result, held until the next load completes
//   mem_address             word-aligned memory address
//   mem_data_in, mem_write  memory write word and write enable
//   mem_data_out            combinational memory read word
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_write,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              err_q;

    logic              misaligned;
    logic [31:0]       load_value;
    logic [31:0]       merged_word;

    assign misaligned = (size == 2'b11)
                     || (size == SZ_HALF && addr[0])
                     || (size == SZ_WORD && addr[1:0] != 2'b00);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (misaligned)        state_d = RESP;
                    else if (!we)          state_d = LOAD;
                    else if (size == SZ_WORD) state_d = STORE;
                    else                   state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = STORE;
            STORE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction and extension for loads (little-endian lanes).
    always_comb begin
        load_value = mem_data_out;
        unique case (size_q)
            SZ_BYTE: begin
                logic [7:0] b;
                b = mem_data_out[8*addr_q[1:0] +: 8];
                load_value = {{24{sign_q & b[7]}}, b};
            end
            SZ_HALF: begin
                logic [15:0] h;
                h = mem_data_out[16*addr_q[1] +: 16];
                load_value = {{16{sign_q & h[15]}}, h};
            end
            default: load_value = mem_data_out;
        endcase
    end

    // Read-modify-write merge: overwrite only the target lane.
    always_comb begin
        merged_word = mem_data_out;
        if (size_q == SZ_BYTE) merged_word[8*addr_q[1:0] +: 8]  = wdata_q[7:0];
        else                   merged_word[16*addr_q[1] +: 16] = wdata_q[15:0];
    end

    // Request capture and datapath registers. rdata only moves leaving LOAD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        size_q  <= size;
                        sign_q  <= sign_ext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err_q   <= misaligned;
                    end
                end
                LOAD:    rdata   <= load_value;
                RMW_RD:  merge_q <= merged_word;
                default: ;
            endcase
        end
    end

    // mem_write is decoded from state alone, so an asynchronous reset that
    // forces IDLE drops it immediately and no partial write commits.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == RESP);
    assign err         = done & err_q;
    assign mem_write   = (state_q == STORE);
    assign mem_address = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_data_in = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule
